// File: rtl/wordle_scorer.sv
// Wordle guess scorer.
// Latches a guess/answer pair on start, marks greens in one cycle, then walks the
// guess positions one per cycle to assign yellows, crediting each answer letter at
// most once. Results are held until the next accepted start.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start_i        score request, only accepted while idle
//   guess_i        player word, letter i at [i*LETTER_W +: LETTER_W]
//   answer_i       target word, same packing
//   busy_o         scoring in progress
//   done_o         one-cycle pulse when results become final
//   valid_o        results valid, from done until the next accepted start
//   greens_o       per-letter exact-position match
//   yellows_o      per-letter present-elsewhere after duplicate accounting
//   win_o          all letters green
//   output_row_o   slot i = {yellows[i], greens[i], guess letter i}
module wordle_scorer #(
  parameter int unsigned NUM_LETTERS = 5,
  parameter int unsigned LETTER_W    = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start_i,
  input  logic [NUM_LETTERS*LETTER_W-1:0]     guess_i,
  input  logic [NUM_LETTERS*LETTER_W-1:0]     answer_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                valid_o,
  output logic [NUM_LETTERS-1:0]              greens_o,
  output logic [NUM_LETTERS-1:0]              yellows_o,
  output logic                                win_o,
  output logic [NUM_LETTERS*(LETTER_W+2)-1:0] output_row_o
);

  localparam int unsigned WordW = NUM_LETTERS * LETTER_W;
  localparam int unsigned SlotW = LETTER_W + 2;
  localparam int unsigned IdxW  = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LETTERS - 1);

  typedef enum logic [1:0] {StIdle, StGreen, StYellow, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WordW-1:0]       guess_q, guess_d;
  logic [WordW-1:0]       answer_q, answer_d;
  logic [NUM_LETTERS-1:0] greens_q, greens_d;
  logic [NUM_LETTERS-1:0] yellows_q, yellows_d;
  // Answer letters already credited to a green or an earlier yellow.
  logic [NUM_LETTERS-1:0] used_q, used_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   win_q, win_d;
  logic                   found;

  logic [LETTER_W-1:0] g_let [NUM_LETTERS];
  logic [LETTER_W-1:0] a_let [NUM_LETTERS];

  for (genvar i = 0; i < NUM_LETTERS; i++) begin : g_unpack
    assign g_let[i] = guess_q[i*LETTER_W +: LETTER_W];
    assign a_let[i] = answer_q[i*LETTER_W +: LETTER_W];
  end

  always_comb begin
    state_d   = state_q;
    guess_d   = guess_q;
    answer_d  = answer_q;
    greens_d  = greens_q;
    yellows_d = yellows_q;
    used_d    = used_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    win_d     = win_q;
    found     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          guess_d   = guess_i;
          answer_d  = answer_i;
          greens_d  = '0;
          yellows_d = '0;
          used_d    = '0;
          valid_d   = 1'b0;
          win_d     = 1'b0;
          state_d   = StGreen;
        end
      end
      StGreen: begin
        for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
          greens_d[i] = (g_let[i] == a_let[i]);
        end
        used_d  = greens_d;
        idx_d   = '0;
        state_d = StYellow;
      end
      StYellow: begin
        if (!greens_q[idx_q]) begin
          // Lowest uncredited answer position holding this letter wins the credit.
          for (int unsigned j = 0; j < NUM_LETTERS; j++) begin
            if (!found && !used_q[j] && (a_let[j] == g_let[idx_q])) begin
              found     = 1'b1;
              used_d[j] = 1'b1;
            end
          end
          if (found) begin
            yellows_d[idx_q] = 1'b1;
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Results become visible together with the done pulse.
          valid_d = 1'b1;
          win_d   = &greens_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      guess_q   <= '0;
      answer_q  <= '0;
      greens_q  <= '0;
      yellows_q <= '0;
      used_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      guess_q   <= guess_d;
      answer_q  <= answer_d;
      greens_q  <= greens_d;
      yellows_q <= yellows_d;
      used_q    <= used_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      win_q     <= win_d;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign valid_o   = valid_q;
  assign greens_o  = greens_q;
  assign yellows_o = yellows_q;
  assign win_o     = win_q;

  always_comb begin
    output_row_o = '0;
    for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
      output_row_o[i*SlotW +: SlotW] = {yellows_q[i], greens_q[i], g_let[i]};
    end
  end

endmodule

// File: tb/tb_wordle_scorer.sv
// Scoreboard bench for wordle_scorer: a 5-letter and a 6-letter instance.
// Expected results come from a letter-count reference model and are queued at
// issue time; per-instance monitors pop and compare on each done pulse.
module tb_wordle_scorer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start5, start6;
  logic [24:0] guess5, answer5;
  logic [29:0] guess6, answer6;
  logic        busy5, done5, valid5, win5;
  logic        busy6, done6, valid6, win6;
  logic [4:0]  greens5, yellows5;
  logic [5:0]  greens6, yellows6;
  logic [34:0] row5;
  logic [41:0] row6;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0]  g;
    logic [5:0]  y;
    logic        win;
    logic [29:0] guess;
    int          acc;
  } exp_t;

  exp_t q5[$];
  exp_t q6[$];

  wordle_scorer #(.NUM_LETTERS(5), .LETTER_W(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(start5), .guess_i(guess5), .answer_i(answer5),
    .busy_o(busy5), .done_o(done5), .valid_o(valid5), .greens_o(greens5),
    .yellows_o(yellows5), .win_o(win5), .output_row_o(row5)
  );

  wordle_scorer #(.NUM_LETTERS(6), .LETTER_W(5)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start_i(start6), .guess_i(guess6), .answer_i(answer6),
    .busy_o(busy6), .done_o(done6), .valid_o(valid6), .greens_o(greens6),
    .yellows_o(yellows6), .win_o(win6), .output_row_o(row6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, want);
    end
  endfunction

  function automatic logic [29:0] wd(input string s);
    logic [29:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i*5 +: 5] = 5'(s[i] - 8'd65);
    return r;
  endfunction

  // Reference: greens by position, then yellows from a multiset of unmatched answer letters.
  function automatic void model(input int n, input logic [29:0] g, input logic [29:0] a,
                                output logic [5:0] gr, output logic [5:0] ye);
    int cnt[32];
    gr = '0;
    ye = '0;
    foreach (cnt[k]) cnt[k] = 0;
    for (int i = 0; i < n; i++) begin
      if (g[i*5 +: 5] == a[i*5 +: 5]) gr[i] = 1'b1;
      else cnt[a[i*5 +: 5]]++;
    end
    for (int i = 0; i < n; i++) begin
      if (!gr[i] && cnt[g[i*5 +: 5]] > 0) begin
        ye[i] = 1'b1;
        cnt[g[i*5 +: 5]]--;
      end
    end
  endfunction

  function automatic logic [41:0] mkrow(input int n, input exp_t e);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*7 +: 7] = {e.y[i], e.g[i], e.guess[i*5 +: 5]};
    return r;
  endfunction

  // Small alphabet half the time so duplicate letters are common.
  function automatic logic [29:0] rnd_word(input int n);
    logic [29:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) r[i*5 +: 5] = 5'($urandom_range(0, 3));
      else r[i*5 +: 5] = 5'($urandom);
    end
    return r;
  endfunction

  task automatic issue(input int n, input logic [29:0] g, input logic [29:0] a,
                       input logic [5:0] eg, input logic [5:0] ey);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (((n == 5) ? busy5 : busy6) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_before_start", (n == 5) ? busy5 : busy6, 0);
    if (n == 5) begin
      guess5 = g[24:0]; answer5 = a[24:0]; start5 = 1'b1;
    end else begin
      guess6 = g; answer6 = a; start6 = 1'b1;
    end
    e.g = eg;
    e.y = ey;
    e.win = (n == 5) ? &eg[4:0] : &eg;
    e.guess = g;
    @(negedge clk);
    start5 = 1'b0;
    start6 = 1'b0;
    e.acc = cyc;
    if (n == 5) begin
      q5.push_back(e);
      chk("busy_after_accept5", busy5, 1);
      chk("valid_cleared5", valid5, 0);
    end else begin
      q6.push_back(e);
      chk("busy_after_accept6", busy6, 1);
    end
  endtask

  task automatic issue_rand(input int n);
    logic [29:0] g, a;
    logic [5:0] eg, ey;
    a = rnd_word(n);
    g = ($urandom_range(0, 7) == 0) ? a : rnd_word(n);
    model(n, g, a, eg, ey);
    issue(n, g, a, eg, ey);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q5.size() != 0 || q6.size() != 0 || busy5 || busy6) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("pending_results", q5.size() + q6.size(), 0);
  endtask

  initial begin : mon5
    exp_t e;
    forever begin
      @(negedge clk);
      if (done5 === 1'b1) begin
        if (q5.size() == 0) chk("unexpected_done5", done5, 0);
        else begin
          e = q5.pop_front();
          chk("greens5", greens5, e.g[4:0]);
          chk("yellows5", yellows5, e.y[4:0]);
          chk("win5", win5, e.win);
          chk("valid_at_done5", valid5, 1);
          chk("row5", row5, mkrow(5, e));
          chk("latency5", cyc - e.acc, 6);
        end
      end
    end
  end

  initial begin : mon6
    exp_t e;
    forever begin
      @(negedge clk);
      if (done6 === 1'b1) begin
        if (q6.size() == 0) chk("unexpected_done6", done6, 0);
        else begin
          e = q6.pop_front();
          chk("greens6", greens6, e.g);
          chk("yellows6", yellows6, e.y);
          chk("win6", win6, e.win);
          chk("valid_at_done6", valid6, 1);
          chk("row6", row6, mkrow(6, e));
          chk("latency6", cyc - e.acc, 7);
        end
      end
    end
  end

  initial begin : main
    logic [5:0] eg, ey;
    rst_n = 1'b0;
    start5 = 1'b0; start6 = 1'b0;
    guess5 = '0; answer5 = '0; guess6 = '0; answer6 = '0;
    #1;
    chk("reset_busy", busy5, 0);
    chk("reset_done", done5, 0);
    chk("reset_valid", valid5, 0);
    chk("reset_colours", {greens5, yellows5, win5}, 0);
    chk("reset_row", row5, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Exact match, then results must hold while idle.
    issue(5, wd("CRANE"), wd("CRANE"), 6'b011111, 6'b000000);
    drain();
    repeat (3) @(negedge clk);
    chk("valid_hold", valid5, 1);
    chk("win_hold", win5, 1);
    chk("greens_hold", greens5, 5'b11111);

    issue(5, wd("PAPER"), wd("APPLE"), 6'b000100, 6'b001011);
    drain();
    chk("paper_slot2", row5[14 +: 7], {2'b01, 5'd15});
    issue(5, wd("AAAAA"), wd("CRANE"), 6'b000100, 6'b000000);
    issue(5, wd("EEEEE"), wd("CRANE"), 6'b010000, 6'b000000);
    drain();

    // Start while busy must be ignored: no re-latch, single done.
    issue(5, wd("PAPER"), wd("APPLE"), 6'b000100, 6'b001011);
    @(negedge clk);
    guess5 = wd("CRANE"); answer5 = wd("CRANE"); start5 = 1'b1;
    repeat (2) @(negedge clk);
    start5 = 1'b0;
    drain();

    // Reset in the middle of the yellow scan.
    @(negedge clk);
    guess5 = wd("EERIE"); answer5 = wd("THERE"); start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_abort", busy5, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy5, 0);
    chk("abort_done", done5, 0);
    chk("abort_valid", valid5, 0);
    chk("abort_colours", {greens5, yellows5, win5}, 0);
    chk("abort_row", row5, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model(5, wd("EERIE"), wd("THERE"), eg, ey);
    issue(5, wd("EERIE"), wd("THERE"), eg, ey);
    drain();

    // Six-letter instance.
    model(6, wd("TALENT"), wd("PLANET"), eg, ey);
    issue(6, wd("TALENT"), wd("PLANET"), eg, ey);
    for (int k = 0; k < 20; k++) issue_rand(6);
    drain();

    // Back-to-back random words.
    for (int k = 0; k < 150; k++) issue_rand(5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
